// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: sequences CPU reset, gates execution in free-run or
// single-step mode, detects halt with a pipeline drain, enforces a cycle
// budget and reports done/timeout plus cycle and retire counts.
module cpu_run_ctrl #(
  parameter int CNT_W        = 32,
  parameter int RESET_CYCLES = 2,
  parameter int MAX_CYCLES   = 20,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             step_mode,
  input  logic             step,
  input  logic             halt_req,
  input  logic             retire,
  output logic             cpu_reset,
  output logic             cpu_en,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] retire_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  // One phase counter serves both the reset hold and the drain countdown.
  localparam int PH_MAX = (RESET_CYCLES > DRAIN_CYCLES) ? RESET_CYCLES : DRAIN_CYCLES;
  localparam int PH_W   = (PH_MAX < 2) ? 1 : $clog2(PH_MAX + 1);

  localparam logic [PH_W-1:0]  RST_LOAD   = PH_W'(RESET_CYCLES - 1);
  localparam logic [PH_W-1:0]  DRAIN_LOAD = PH_W'(DRAIN_CYCLES);
  localparam logic [PH_W-1:0]  PH_ONE     = PH_W'(1);
  localparam logic [CNT_W-1:0] MAX_C      = CNT_W'(MAX_CYCLES);
  localparam bit               HAS_BUDGET = (MAX_CYCLES != 0);

  state_t            state_q, state_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [CNT_W-1:0]  cyc_d, ret_d;
  logic              done_d, to_d;
  logic [CNT_W-1:0]  cyc_inc;
  logic              budget_hit;

  // Counters stop at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Next-state, counter updates and combinational CPU controls.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    cyc_d      = cycle_count;
    ret_d      = retire_count;
    done_d     = done;
    to_d       = timeout;
    cpu_en     = 1'b0;
    cpu_reset  = 1'b0;
    busy       = 1'b0;
    cyc_inc    = sat_inc(cycle_count);
    budget_hit = HAS_BUDGET && (cyc_inc == MAX_C);

    case (state_q)
      S_IDLE, S_DONE: begin
        cpu_reset = (state_q == S_IDLE);
        if (start) begin
          state_d = S_RST;
          phase_d = RST_LOAD;
          cyc_d   = '0;
          ret_d   = '0;
          done_d  = 1'b0;
          to_d    = 1'b0;
        end
      end
      S_RST: begin
        cpu_reset = 1'b1;
        busy      = 1'b1;
        if (phase_q == '0) state_d = S_RUN;
        else               phase_d = phase_q - 1'b1;
      end
      S_RUN: begin
        busy   = 1'b1;
        cpu_en = step_mode ? step : 1'b1;
        if (cpu_en) begin
          cyc_d = cyc_inc;
          // Budget takes priority over a halt seen on the same cycle.
          if (budget_hit) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            to_d    = 1'b1;
          end else if (halt_req) begin
            if (DRAIN_CYCLES == 0) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = S_DRAIN;
              phase_d = DRAIN_LOAD;
            end
          end
        end
      end
      S_DRAIN: begin
        busy   = 1'b1;
        cpu_en = step_mode ? step : 1'b1;
        if (cpu_en) begin
          cyc_d   = cyc_inc;
          phase_d = phase_q - 1'b1;
          if (budget_hit) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            to_d    = 1'b1;
          end else if (phase_q == PH_ONE) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Retirements only count on cycles the CPU actually advanced.
    if (cpu_en && retire) ret_d = sat_inc(retire_count);
  end

  // State, phase counter, flags and counters with asynchronous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      phase_q      <= '0;
      cycle_count  <= '0;
      retire_count <= '0;
      done         <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      cycle_count  <= cyc_d;
      retire_count <= ret_d;
      done         <= done_d;
      timeout      <= to_d;
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Testbench for cpu_run_ctrl: scoreboard of expected run results pushed at
// launch and compared when the run reports done.
module tb_cpu_run_ctrl;

  localparam int CNT_W        = 32;
  localparam int RESET_CYCLES = 2;
  localparam int MAX_CYCLES   = 20;
  localparam int DRAIN_CYCLES = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             step_mode;
  logic             step;
  logic             halt_req;
  logic             retire;
  logic             cpu_reset;
  logic             cpu_en;
  logic             busy;
  logic             done;
  logic             timeout;
  logic [CNT_W-1:0] cycle_count;
  logic [CNT_W-1:0] retire_count;

  typedef struct {
    int cyc;
    int ret;
    bit to;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  cpu_run_ctrl #(
    .CNT_W(CNT_W), .RESET_CYCLES(RESET_CYCLES),
    .MAX_CYCLES(MAX_CYCLES), .DRAIN_CYCLES(DRAIN_CYCLES)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .step_mode(step_mode),
    .step(step), .halt_req(halt_req), .retire(retire),
    .cpu_reset(cpu_reset), .cpu_en(cpu_en), .busy(busy), .done(done),
    .timeout(timeout), .cycle_count(cycle_count), .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one cycle and walk through the reset hold.
  task automatic launch();
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("rst_cpu_reset", cpu_reset, 1);
    chk("rst_busy", busy, 1);
    chk("rst_done_clr", done, 0);
    chk("rst_to_clr", timeout, 0);
    chk("rst_cyc_clr", cycle_count, 0);
    chk("rst_ret_clr", retire_count, 0);
    for (int i = 1; i < RESET_CYCLES; i++) begin
      cyc();
      chk("rst_hold", cpu_reset, 1);
    end
    cyc();
    chk("run_cpu_reset", cpu_reset, 0);
    chk("run_busy", busy, 1);
  endtask

  // Pop the expected result of the finished run and compare.
  task automatic compare_sb(input int en_cnt);
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_empty", 0, 1);
      return;
    end
    e = sb.pop_front();
    chk("end_cycle_count", cycle_count, e.cyc);
    chk("end_retire_count", retire_count, e.ret);
    chk("end_timeout", timeout, e.to);
    chk("end_en_cycles", en_cnt, e.cyc);
    chk("end_cpu_en", cpu_en, 0);
    chk("end_cpu_reset", cpu_reset, 0);
    chk("end_busy", busy, 0);
    cyc();
    chk("done_held", done, 1);
  endtask

  // Free-run until done; halt at enabled-cycle index halt_at, start pulse
  // at index start_at (must be inside RUN to test that it is ignored).
  task automatic run_until_done(input int halt_at, input bit ret_on,
                                input int start_at, input int en_base);
    int idx = 0;
    int en  = en_base;
    bit seen = 1'b0;
    for (int g = 0; g < 200; g++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      halt_req = (idx == halt_at);
      retire   = ret_on;
      start    = (idx == start_at);
      #1;
      if (cpu_en) en++;
      cyc();
      if (idx == start_at) begin
        start = 1'b0;
        chk("start_ign_cnt", cycle_count, idx + 1);
        chk("start_ign_rst", cpu_reset, 0);
      end
      idx++;
    end
    halt_req = 1'b0;
    retire   = 1'b0;
    start    = 1'b0;
    if (!seen) chk("done_wait", 0, 1);
    else       compare_sb(en);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; step_mode = 1'b0; step = 1'b0;
    halt_req = 1'b0; retire = 1'b0;
    #1;
    chk("rv_cpu_reset", cpu_reset, 1);
    chk("rv_cpu_en", cpu_en, 0);
    chk("rv_busy", busy, 0);
    chk("rv_done", done, 0);
    chk("rv_timeout", timeout, 0);
    chk("rv_cyc", cycle_count, 0);
    chk("rv_ret", retire_count, 0);
    cyc();
    cyc();
    reset = 1'b1;
    cyc();
    chk("idle_cpu_reset", cpu_reset, 1);

    // Budget run, no halt.
    sb.push_back('{20, 0, 1'b1});
    launch();
    run_until_done(-1, 1'b0, -1, 0);

    // Halt at count 7 with retire every cycle.
    sb.push_back('{12, 12, 1'b0});
    launch();
    run_until_done(7, 1'b1, -1, 0);

    // Single-step: five steps with three idle cycles after each.
    step_mode = 1'b1;
    sb.push_back('{10, 10, 1'b0});
    launch();
    for (int p = 0; p < 5; p++) begin
      for (int j = 0; j < 4; j++) begin
        step   = (j == 0);
        retire = 1'b1;
        #1;
        chk("step_en", cpu_en, step);
        cyc();
      end
    end
    step = 1'b0;
    retire = 1'b0;
    chk("step_cyc", cycle_count, 5);
    chk("step_ret", retire_count, 5);
    step_mode = 1'b0;
    run_until_done(0, 1'b1, -1, 5);

    // Halt on the budget cycle: no drain.
    sb.push_back('{20, 0, 1'b1});
    launch();
    run_until_done(19, 1'b0, -1, 0);

    // Halt at 17: drain cut short by budget.
    sb.push_back('{20, 0, 1'b1});
    launch();
    run_until_done(17, 1'b0, -1, 0);

    // Asynchronous reset mid-run at count 9.
    launch();
    for (int i = 0; i < 9; i++) begin
      retire = 1'b1;
      cyc();
    end
    retire = 1'b0;
    chk("pre_arst_cyc", cycle_count, 9);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_cpu_reset", cpu_reset, 1);
    chk("arst_busy", busy, 0);
    chk("arst_cpu_en", cpu_en, 0);
    chk("arst_cyc", cycle_count, 0);
    chk("arst_ret", retire_count, 0);
    @(negedge clk);
    reset = 1'b1;
    cyc();
    sb.push_back('{8, 8, 1'b0});
    launch();
    run_until_done(3, 1'b1, -1, 0);

    // Start in RUN is ignored; start in DONE restarts cleanly.
    sb.push_back('{15, 15, 1'b0});
    launch();
    run_until_done(10, 1'b1, 5, 0);
    sb.push_back('{20, 20, 1'b1});
    launch();
    run_until_done(-1, 1'b1, -1, 0);

    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Parametrised run controller for the pipelined CPU. It sequences the CPU reset, gates execution with a per-cycle enable in free-run or single-step mode, and detects halt with a pipeline drain. It enforces a cycle budget and reports done, timeout and cycle/retire counts. It sits between the top-level stimulus or host and the CPU core, replacing hand-counted reset and run loops.

## Interface
- `CNT_W`, default 32: width of `cycle_count` and `retire_count`.
- `RESET_CYCLES`, default 2: cycles `cpu_reset` is held after `start`. Must be ≥1.
- `MAX_CYCLES`, default 20: cycle budget in enabled cycles. 0 means unlimited.
- `DRAIN_CYCLES`, default 4: enabled cycles run after halt so the pipeline drains. May be 0.

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `start`  in  1: launch a run. Sampled in IDLE or DONE only.
- `step_mode`  in  1: 1 selects single-step; 0 selects free-run. Sampled every cycle.
- `step`  in  1: in step mode, enables exactly the current cycle.
- `halt_req`  in  1: CPU reports a halt instruction. Valid only when `cpu_en`=1.
- `retire`  in  1: CPU retired one instruction this cycle.
- `cpu_reset`  out  1: active-high reset to the CPU core.
- `cpu_en`  out  1: CPU clock-enable for this cycle.
- `busy`  out  1: high in RST, RUN and DRAIN.
- `done`  out  1: run finished. Held until the next `start` or `reset`.
- `timeout`  out  1: run ended on the budget rather than on halt.
- `cycle_count`  out  `CNT_W`: enabled cycles in the current or last run.
- `retire_count`  out  `CNT_W`: retired instructions in the current or last run.

## Operation
- States: IDLE, RST, RUN, DRAIN, DONE.
- Reset values (`reset`=0): state IDLE, `cpu_reset`=1, `cpu_en`=0, `busy`=0, `done`=0, `timeout`=0, both counters 0.
- `cpu_reset`=1 in IDLE and RST, 0 otherwise. `busy` is a state decode.
- `cpu_en`: in RUN and DRAIN it equals `step_mode ? step : 1`. It is 0 in all other states. It is combinational from state and inputs.
- IDLE or DONE with `start`=1 → RST. The same edge clears both counters, `done` and `timeout`, and loads the phase counter.
- RST: stays for exactly `RESET_CYCLES` cycles, then → RUN.
- RUN: on each cycle with `cpu_en`=1, `cycle_count` increments.
  - If the new `cycle_count` equals `MAX_CYCLES` (nonzero) → DONE with `timeout`=1. Budget wins over a simultaneous `halt_req`.
  - Otherwise, if `halt_req`=1 → DRAIN with the drain counter loaded to `DRAIN_CYCLES`. If `DRAIN_CYCLES`=0, go directly to DONE instead.
- DRAIN: each enabled cycle increments `cycle_count` and decrements the drain counter. Reaching 0 → DONE with `timeout`=0. Hitting the budget first → DONE with `timeout`=1. `halt_req` is ignored.
- `retire_count` increments when `retire`=1 and `cpu_en`=1.
- Cycles with `cpu_en`=0 (step mode, no `step`) change nothing except state-independent sampling.
- DONE: `cpu_en`=0 and `cpu_reset`=0, so CPU state is held for inspection. `done`=1.
- Counters saturate at all-ones and never wrap.
- `start` in RST, RUN or DRAIN is ignored.
- Changing `step_mode` mid-run takes effect on the same cycle.

## Timing
- `start` high at edge k → state RST from k. `cpu_reset` stays 1 through edge k+`RESET_CYCLES`. The first RUN cycle (`cpu_reset`=0, `cpu_en` possible) starts at edge k+`RESET_CYCLES`.
- State, `done`, `timeout` and counters are registered; they update on the edge that ends the qualifying cycle. `cpu_en` and `cpu_reset` are combinational from state and inputs.
- `done` rises on the edge that enters DONE.
- The halt cycle itself is counted. Halt seen at `cycle_count`=n gives a final count of n+1+`DRAIN_CYCLES`, budget permitting.
- `reset` low at any time, including mid-RUN or mid-DRAIN, forces reset values immediately, without waiting for a clock edge.
- Removal of `reset` is synchronised by the integrator. The block needs no `start` in the first cycle after deassertion.

## Test plan
- Defaults, reset low then high, `start` one cycle, no halt → `cpu_reset`=1 for 2 cycles, then 20 cycles with `cpu_en`=1. Then `done`=1, `timeout`=1, `cycle_count`=20, `cpu_en`=0.
- Free-run, `halt_req` asserted while `cycle_count`=7, `retire` every cycle → 4 drain cycles, then `done`=1, `timeout`=0, `cycle_count`=12, `retire_count`=12.
- `step_mode`=1, five one-cycle `step` pulses separated by 3 idle cycles → `cycle_count`=5. `cpu_en` is high only on step cycles; `retire` on non-step cycles is not counted.
- `halt_req` on the cycle where `cycle_count` goes 19→20 → DONE with `timeout`=1, with no DRAIN. Separately, halt at count 17 → DRAIN ends by budget at 20 with `timeout`=1.
- `reset` pulled low asynchronously mid-RUN at count 9 → `cpu_reset`=1, `busy`=0 and counters 0 before the next edge. `start` afterwards runs a clean sequence.
- `start` pulsed in RUN → ignored, no counter change. `start` in DONE → counters, `done` and `timeout` cleared, and the RST sequence repeats.
